// File: rtl/pll_reset_sequencer.sv
// PLL reset sequencer: pulses the PLL reset, waits for a stable synchronized lock,
// then holds system reset for a fixed time before declaring the clock domain ready.
module pll_reset_sequencer #(
  parameter int PLL_RST_CYCLES      = 16,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int LOCK_TIMEOUT_CYCLES = 1000000,
  parameter int SYS_RST_CYCLES      = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pll_locked,
  output logic       pll_rst,
  output logic       sys_rst,
  output logic       ready,
  output logic [1:0] state,
  output logic [7:0] retry_count,
  output logic [7:0] loss_count
);

  localparam int MAX_A      = (PLL_RST_CYCLES > SYS_RST_CYCLES) ? PLL_RST_CYCLES : SYS_RST_CYCLES;
  localparam int MAX_B      = (LOCK_TIMEOUT_CYCLES > LOCK_STABLE_CYCLES) ? LOCK_TIMEOUT_CYCLES : LOCK_STABLE_CYCLES;
  localparam int MAX_CYCLES = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);
  localparam int STB_W      = $clog2(LOCK_STABLE_CYCLES + 1);

  localparam logic [CNT_W-1:0] PLL_LAST     = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(SYS_RST_CYCLES - 1);
  localparam logic [STB_W-1:0] STABLE_LAST  = STB_W'(LOCK_STABLE_CYCLES - 1);

  typedef enum logic [1:0] {
    RESET_PLL = 2'd0,
    WAIT_LOCK = 2'd1,
    HOLD      = 2'd2,
    RUN       = 2'd3
  } state_t;

  state_t            state_r, state_nxt;
  logic [CNT_W-1:0]  cnt_r, cnt_nxt;
  logic [STB_W-1:0]  stable_r, stable_nxt;
  logic              sync_meta_r;
  logic              locked_s;
  logic              retry_inc_s;
  logic              loss_inc_s;

  assign state = state_r;

  // Two-flop synchronizer for the asynchronous lock indication
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_meta_r <= 1'b0;
      locked_s    <= 1'b0;
    end else begin
      sync_meta_r <= pll_locked;
      locked_s    <= sync_meta_r;
    end
  end

  // Next-state, shared cycle counter and lock-stability counter
  always_comb begin
    state_nxt   = state_r;
    cnt_nxt     = cnt_r;
    stable_nxt  = stable_r;
    retry_inc_s = 1'b0;
    loss_inc_s  = 1'b0;
    case (state_r)
      RESET_PLL: begin
        stable_nxt = {STB_W{1'b0}};
        if (cnt_r == PLL_LAST) begin
          state_nxt = WAIT_LOCK;
          cnt_nxt   = {CNT_W{1'b0}};
        end else begin
          cnt_nxt = cnt_r + CNT_W'(1);
        end
      end
      WAIT_LOCK: begin
        // Acceptance is checked before timeout so it wins a same-cycle tie
        if (locked_s && (stable_r == STABLE_LAST)) begin
          state_nxt  = HOLD;
          cnt_nxt    = {CNT_W{1'b0}};
          stable_nxt = {STB_W{1'b0}};
        end else if (cnt_r == TIMEOUT_LAST) begin
          state_nxt   = RESET_PLL;
          cnt_nxt     = {CNT_W{1'b0}};
          stable_nxt  = {STB_W{1'b0}};
          retry_inc_s = 1'b1;
        end else begin
          cnt_nxt    = cnt_r + CNT_W'(1);
          stable_nxt = locked_s ? (stable_r + STB_W'(1)) : {STB_W{1'b0}};
        end
      end
      HOLD: begin
        if (!locked_s) begin
          state_nxt  = RESET_PLL;
          cnt_nxt    = {CNT_W{1'b0}};
          loss_inc_s = 1'b1;
        end else if (cnt_r == HOLD_LAST) begin
          state_nxt = RUN;
          cnt_nxt   = {CNT_W{1'b0}};
        end else begin
          cnt_nxt = cnt_r + CNT_W'(1);
        end
      end
      RUN: begin
        if (!locked_s) begin
          state_nxt  = RESET_PLL;
          cnt_nxt    = {CNT_W{1'b0}};
          loss_inc_s = 1'b1;
        end else begin
          cnt_nxt = {CNT_W{1'b0}};
        end
      end
      default: begin
        state_nxt  = RESET_PLL;
        cnt_nxt    = {CNT_W{1'b0}};
        stable_nxt = {STB_W{1'b0}};
      end
    endcase
  end

  // State, counters and registered outputs decoded from the next state
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= RESET_PLL;
      cnt_r       <= {CNT_W{1'b0}};
      stable_r    <= {STB_W{1'b0}};
      pll_rst     <= 1'b1;
      sys_rst     <= 1'b1;
      ready       <= 1'b0;
      retry_count <= 8'd0;
      loss_count  <= 8'd0;
    end else begin
      state_r  <= state_nxt;
      cnt_r    <= cnt_nxt;
      stable_r <= stable_nxt;
      pll_rst  <= (state_nxt == RESET_PLL);
      sys_rst  <= (state_nxt != RUN);
      ready    <= (state_nxt == RUN);
      if (retry_inc_s && (retry_count != 8'hFF)) begin
        retry_count <= retry_count + 8'd1;
      end else begin
        retry_count <= retry_count;
      end
      if (loss_inc_s && (loss_count != 8'hFF)) begin
        loss_count <= loss_count + 8'd1;
      end else begin
        loss_count <= loss_count;
      end
    end
  end

endmodule
